// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit for a MIPS-style pipeline: one shift-add or
// restoring shift-subtract step per cycle, then a sign-fixup cycle that writes HI/LO.
module muldiv_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [1:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          mfhi_i,
    input  logic          mflo_i,
    input  logic          mthi_i,
    input  logic          mtlo_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          abort_i,
    output logic [DW-1:0] rdata_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          busy_o,
    output logic          stall_o
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic            is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
    logic [DW-1:0]   opnd_q, opnd_d, araw_q, araw_d, acc_lo_q, acc_lo_d;
    logic [DW:0]     acc_hi_q, acc_hi_d;

    logic            signed_op, a_neg, b_neg;
    logic [DW-1:0]   a_mag, b_mag;
    logic [DW:0]     mul_sum, div_shift, div_diff;
    logic [2*DW-1:0] prod_mag, prod;
    logic [DW-1:0]   quo, rem;

    assign signed_op = ~op_i[0];
    assign a_neg     = signed_op & a_i[DW-1];
    assign b_neg     = signed_op & b_i[DW-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // acc_hi carries one extra bit so the multiply carry-out and divide borrow survive the step.
    assign mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi_q[DW-1:0], acc_lo_q[DW-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod_mag  = {acc_hi_q[DW-1:0], acc_lo_q};
    assign prod      = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    assign quo       = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
    assign rem       = sa_q ? -acc_hi_q[DW-1:0] : acc_hi_q[DW-1:0];

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        opnd_d   = opnd_q;
        araw_d   = araw_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (mthi_i) hi_d = wdata_i;
                if (mtlo_i) lo_d = wdata_i;
                if (start_i && !abort_i) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op_i[1];
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    bz_d     = (b_i == '0);
                    araw_d   = a_i;
                    acc_hi_d = '0;
                    acc_lo_d = op_i[1] ? a_mag : b_mag;
                    opnd_d   = op_i[1] ? b_mag : a_mag;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) state_d = S_FIX;
                    if (!is_div_q) begin
                        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q} >> 1;
                    end else if (!div_diff[DW]) begin
                        acc_hi_d = div_diff;
                        acc_lo_d = {acc_lo_q[DW-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift;
                        acc_lo_d = {acc_lo_q[DW-2:0], 1'b0};
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!abort_i) begin
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (bz_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: datapath registers are left unreset; they are always loaded before they are read.
    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        sa_q     <= sa_d;
        sb_q     <= sb_d;
        bz_q     <= bz_d;
        opnd_q   <= opnd_d;
        araw_q   <= araw_d;
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
    end

    assign busy_o  = (state_q != S_IDLE);
    assign stall_o = busy_o & (start_i | mfhi_i | mflo_i | mthi_i | mtlo_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign rdata_o = mfhi_i ? hi_q : lo_q;
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand/HI/LO width; iteration count equals DW.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  EX stage issues a mult/multu/div/divu this cycle.
REQ-005 SHALL have port op_i  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port a_i  input  DW  rs operand (dividend / multiplicand).
REQ-007 SHALL have port b_i  input  DW  rt operand (divisor / multiplier).
REQ-008 SHALL have ports mfhi_i, mflo_i  input  1 each  EX stage reads HI / LO this cycle.
REQ-009 SHALL have ports mthi_i, mtlo_i  input  1 each  EX stage writes HI / LO this cycle.
REQ-010 SHALL have port wdata_i  input  DW  data for mthi/mtlo.
REQ-011 SHALL have port abort_i  input  1  pipeline flush; cancels an in-flight operation.
REQ-012 SHALL have port rdata_o  output  DW  HI when mfhi_i, else LO (combinational mux of registers).
REQ-013 SHALL have ports hi_o, lo_o  output  DW each  current HI / LO registers.
REQ-014 SHALL have port busy_o  output  1  operation in flight.
REQ-015 SHALL have port stall_o  output  1  freeze IF/ID/EX this cycle.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIX.
REQ-017 IDLE: start_i & ~abort_i latches op, |a|, |b|, sign bits; counter cleared; next state RUN.
REQ-018 RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; exactly DW cycles; after last step, next state FIX.
REQ-019 FIX: apply sign correction, write HI/LO at end of cycle, next state IDLE.
REQ-020 Latency: start in cycle N -> RUN N+1..N+DW -> FIX N+DW+1 -> HI/LO valid from cycle N+DW+2 (N+34 at DW=32).
REQ-021 busy_o SHALL be 1 in RUN and FIX, 0 in IDLE.
REQ-022 Signed ops (mult, div) use magnitudes; unsigned ops use raw operands.
REQ-023 mult/multu: {HI,LO} = full 2*DW-bit product; signed product negated when sign(a) xor sign(b).
REQ-024 div/divu: LO = quotient, HI = remainder; signed quotient truncates toward zero (negated when signs differ); remainder takes sign of dividend.
REQ-025 Divide by zero (b_i = 0): LO = all ones, HI = a_i unchanged; no trap; same latency.
REQ-026 Signed overflow (div of most-negative by -1): LO = most-negative, HI = 0.
REQ-027 stall_o = busy_o & (start_i | mfhi_i | mflo_i | mthi_i | mtlo_i); 0 otherwise.
REQ-028 start_i while busy SHALL be ignored (held by stall_o) and accepted in the first IDLE cycle it remains asserted.
REQ-029 mthi/mtlo write HI/LO only when IDLE and not stalled; mthi_i and start_i in the same IDLE cycle: write HI, then operation result overwrites HI at FIX.
REQ-030 abort_i in RUN or FIX: return to IDLE next cycle, HI/LO unchanged, busy_o 0 next cycle; abort_i with start_i in IDLE: start ignored.
REQ-031 rdata_o in the cycle the stall drops SHALL reflect the FIX-written value.

Reset
REQ-032 reset SHALL force state IDLE, counter 0, HI = 0, LO = 0, busy_o = 0, stall_o = 0; reset overrides all inputs, including mid-operation (result discarded).

Verification
REQ-033 mult a=0xFFFFFFFD (-3), b=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy_o high exactly cycles N+1..N+33.
REQ-034 divu a=100, b=7 -> LO=0x0000000E, HI=0x00000002; div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 div a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 multu 0xFFFFFFFF*0xFFFFFFFF then mflo held from N+1 -> stall_o=1 until N+33, rdata_o=0x00000001 at N+34 with stall_o=0; HI=0xFFFFFFFE.
REQ-037 mthi 0xAAAA0000 then div started, abort_i at N+10 -> busy_o 0 at N+11, HI=0xAAAA0000, LO unchanged; reset at N+5 of another op -> HI=LO=0, IDLE.
